// File: rtl/ddr3_iod_dly_if.sv
// Request / IOD control bundle between the training sequencer, the delay
// controller and the lane IOD wrapper. The slave modport is the controller side.
interface ddr3_iod_dly_if #(
    parameter int TAP_W = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic [TAP_W-1:0] req_tap;
    logic             out_of_range;
    logic             delay_line_load;
    logic             delay_line_direction;
    logic             delay_line_move;
    logic [TAP_W-1:0] cur_tap;
    logic             done;
    logic             done_err;
    logic             err_oor;
    logic             err_clr;

    modport slave (
        input  req_valid, req_load, req_tap, out_of_range, err_clr,
        output req_ready, delay_line_load, delay_line_direction, delay_line_move,
               cur_tap, done, done_err, err_oor
    );

    modport master (
        output req_valid, req_load, req_tap, out_of_range, err_clr,
        input  req_ready, delay_line_load, delay_line_direction, delay_line_move,
               cur_tap, done, done_err, err_oor
    );
endinterface

// File: rtl/ddr3_iod_dly_ctrl.sv
// Fabric-side sequencer for one DDR3 address/command IOD output delay line.
// Turns tap-set / reload requests into LOAD / MOVE pulses separated by settle
// gaps, tracks the current tap and traps OUT_OF_RANGE reported by the IOD.
//
// state  | meaning
// IDLE   | ready for a request; target and direction latched on accept
// LOAD   | one-cycle DELAY_LINE_LOAD pulse, tracked tap returns to INIT_TAP
// MOVE   | one-cycle DELAY_LINE_MOVE pulse, tracked tap steps by one
// SETTLE | SETTLE_CYC idle cycles; out-of-range sampled on the last one
// FIN    | one-cycle DONE pulse (DONE_ERR if the request was aborted)
module ddr3_iod_dly_ctrl #(
    parameter int TAP_W      = 8,
    parameter int INIT_TAP   = 1,
    parameter int MAX_TAP    = 255,
    parameter int SETTLE_CYC = 4
) (
    input logic fab_clk_i,
    input logic arst_n_i,
    ddr3_iod_dly_if.slave dly
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [TAP_W-1:0] TAP_INIT    = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MOVE,
        ST_SETTLE,
        ST_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             from_load_q, from_load_d;
    logic             done_err_q, done_err_d;
    logic             err_oor_q, err_oor_d;
    logic [TAP_W-1:0] req_target;
    logic             err_set;

    // State and datapath registers; reset matches the IOD's own reset tap.
    always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            cur_tap_q   <= TAP_INIT;
            target_q    <= TAP_INIT;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            from_load_q <= 1'b0;
            done_err_q  <= 1'b0;
            err_oor_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_tap_q   <= cur_tap_d;
            target_q    <= target_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            from_load_q <= from_load_d;
            done_err_q  <= done_err_d;
            err_oor_q   <= err_oor_d;
        end
    end

    // Next-state logic: request accept, tap stepping, settle timing and trap handling.
    always_comb begin
        state_d     = state_q;
        cur_tap_d   = cur_tap_q;
        target_d    = target_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        from_load_d = from_load_q;
        done_err_d  = done_err_q;
        err_set     = 1'b0;
        // A reload is treated as a request whose target is INIT_TAP.
        req_target  = dly.req_load ? TAP_INIT
                    : ((dly.req_tap > TAP_MAX) ? TAP_MAX : dly.req_tap);

        case (state_q)
            ST_IDLE: begin
                if (dly.req_valid) begin
                    target_d   = req_target;
                    dir_d      = (req_target > cur_tap_q);
                    done_err_d = 1'b0;
                    if (dly.req_load) begin
                        state_d = ST_LOAD;
                    end else if (req_target == cur_tap_q) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_LOAD: begin
                cur_tap_d   = TAP_INIT;
                from_load_d = 1'b1;
                cnt_d       = SETTLE_LAST;
                state_d     = ST_SETTLE;
            end
            ST_MOVE: begin
                if (dir_q) begin
                    if (cur_tap_q < TAP_MAX) cur_tap_d = cur_tap_q + TAP_ONE;
                end else begin
                    if (cur_tap_q != '0) cur_tap_d = cur_tap_q - TAP_ONE;
                end
                from_load_d = 1'b0;
                cnt_d       = SETTLE_LAST;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (dly.out_of_range) begin
                    // The IOD refused the last step, so take it back out of the tracked tap.
                    if (!from_load_q) begin
                        if (dir_q) begin
                            if (cur_tap_q != '0) cur_tap_d = cur_tap_q - TAP_ONE;
                        end else begin
                            if (cur_tap_q < TAP_MAX) cur_tap_d = cur_tap_q + TAP_ONE;
                        end
                    end
                    err_set    = 1'b1;
                    done_err_d = 1'b1;
                    state_d    = ST_FIN;
                end else if (cur_tap_q == target_q) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new trap outranks a clear arriving in the same cycle.
        if (err_set) begin
            err_oor_d = 1'b1;
        end else if (dly.err_clr) begin
            err_oor_d = 1'b0;
        end else begin
            err_oor_d = err_oor_q;
        end
    end

    assign dly.req_ready            = (state_q == ST_IDLE);
    assign dly.delay_line_load      = (state_q == ST_LOAD);
    assign dly.delay_line_move      = (state_q == ST_MOVE);
    assign dly.delay_line_direction = dir_q;
    assign dly.cur_tap              = cur_tap_q;
    assign dly.done                 = (state_q == ST_FIN);
    assign dly.done_err             = (state_q == ST_FIN) && done_err_q;
    assign dly.err_oor              = err_oor_q;
endmodule
